// File: rtl/approx_mul_sweep_ctrl.sv
// Exhaustive 8x8 operand sweep for characterising an approximate multiplier:
// drives every (a,b) pair, compares p_in to the exact product and accumulates error statistics.
module approx_mul_sweep_ctrl #(
  parameter int unsigned HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  input  logic [15:0] p_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] num_correct,
  output logic [16:0] num_wrong,
  output logic [15:0] max_err,
  output logic [31:0] err_sum,
  output logic [7:0]  first_a,
  output logic [7:0]  first_b,
  output logic        first_valid,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_clear;
  logic [3:0]  r_hold;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [16:0] r_num_correct;
  logic [16:0] r_num_wrong;
  logic [15:0] r_max_err;
  logic [31:0] r_err_sum;
  logic [7:0]  r_first_a;
  logic [7:0]  r_first_b;
  logic        r_first_valid;

  logic        w_run_ok;
  logic        w_sample;
  logic        w_last;
  logic [15:0] w_exact;
  logic [15:0] w_err;

  // An abort edge never samples, even when the hold counter says it should.
  assign w_run_ok = (r_state == S_RUN) && !abort;
  assign w_sample = w_run_ok && (r_hold == HOLD_LAST);
  assign w_last   = (r_a == 8'hFF) && (r_b == 8'hFF);
  assign w_exact  = 16'(r_a) * 16'(r_b);
  assign w_err    = (p_in >= w_exact) ? (p_in - w_exact) : (w_exact - p_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
        end
      end
      S_RUN: begin
        if (abort)                    w_state_nxt = S_IDLE;
        else if (w_sample && w_last)  w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_num_correct <= '0;
      r_num_wrong   <= '0;
      r_max_err     <= '0;
      r_err_sum     <= '0;
      r_first_a     <= '0;
      r_first_b     <= '0;
      r_first_valid <= 1'b0;
    end else if (w_clear) begin
      r_hold        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_num_correct <= '0;
      r_num_wrong   <= '0;
      r_max_err     <= '0;
      r_err_sum     <= '0;
      r_first_a     <= '0;
      r_first_b     <= '0;
      r_first_valid <= 1'b0;
    end else if (w_run_ok) begin
      r_hold <= w_sample ? 4'd0 : r_hold + 4'd1;
      if (w_sample) begin
        if (w_err == 16'd0) r_num_correct <= r_num_correct + 17'd1;
        else                r_num_wrong   <= r_num_wrong + 17'd1;
        r_err_sum <= r_err_sum + {16'd0, w_err};
        if (w_err > r_max_err) r_max_err <= w_err;
        if ((w_err != 16'd0) && !r_first_valid) begin
          r_first_a     <= r_a;
          r_first_b     <= r_b;
          r_first_valid <= 1'b1;
        end
        // Final pair leaves the operands parked at (255,255).
        if (!w_last) begin
          r_b <= r_b + 8'd1;
          if (r_b == 8'hFF) r_a <= r_a + 8'd1;
        end
      end
    end
  end

  assign a_out       = r_a;
  assign b_out       = r_b;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign num_correct = r_num_correct;
  assign num_wrong   = r_num_wrong;
  assign max_err     = r_max_err;
  assign err_sum     = r_err_sum;
  assign first_a     = r_first_a;
  assign first_b     = r_first_b;
  assign first_valid = r_first_valid;
  assign dbg_state   = r_state;

endmodule
